// File: rtl/stream_conv2d.sv
// Streaming K x K multi-channel 2-D convolution engine.
// Raster-order, channel-interleaved pixels are written into a K-row line
// buffer. Each completed window runs a serial MAC over K*K*CH taps; the
// requantised result (shift, ReLU, saturate) is then held on a valid/ready
// output until it is taken.
module stream_conv2d #(
  parameter int DATA_W    = 8,
  parameter int WGT_W     = 8,
  parameter int ACC_W     = 24,
  parameter int K         = 2,
  parameter int CH        = 3,
  parameter int IMG_W     = 4,
  parameter int IMG_H     = 4,
  parameter int STRIDE    = 2,
  parameter int OUT_SHIFT = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_W-1:0]         in_data,
  input  logic [K*K*CH*WGT_W-1:0]   weights,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W-1:0]         out_data,
  output logic                      out_last,
  output logic                      busy
);

  localparam int N      = K * K * CH;
  localparam int DEPTH  = K * IMG_W * CH;
  localparam int OUT_W  = (IMG_W - K) / STRIDE + 1;
  localparam int OUT_H  = (IMG_H - K) / STRIDE + 1;
  localparam int CH_W   = (CH > 1) ? $clog2(CH) : 1;
  localparam int COL_W  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int ROW_W  = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int K_W    = (K > 1) ? $clog2(K) : 1;
  localparam int IDX_W  = (N > 1) ? $clog2(N) : 1;
  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PROD_W = WGT_W + DATA_W + 1;
  localparam logic [ACC_W-1:0] SAT_MAX = ACC_W'({DATA_W{1'b1}});

  typedef enum logic [1:0] {
    ST_STREAM = 2'd0,
    ST_MAC    = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

  state_t state_r, state_s;

  // input-side position counters and write row slot (row_cnt mod K)
  logic [CH_W-1:0]   ch_cnt_r;
  logic [COL_W-1:0]  col_cnt_r;
  logic [ROW_W-1:0]  row_cnt_r;
  logic [K_W-1:0]    wr_slot_r;

  // window / MAC context
  logic [K_W-1:0]    rd_slot_r;
  logic [COL_W-1:0]  win_col_r;
  logic              win_last_r;
  logic [K_W-1:0]    kx_r;
  logic [CH_W-1:0]   c_r;
  logic [IDX_W-1:0]  idx_r;
  logic [ACC_W-1:0]  acc_r;

  // registered outputs
  logic              in_ready_r;
  logic              out_valid_r;
  logic [DATA_W-1:0] out_data_r;
  logic              out_last_r;
  logic              busy_r;

  logic [DATA_W-1:0] line_buf [DEPTH];

  logic                     accept_s;
  logic                     row_ok_s;
  logic                     col_ok_s;
  logic                     trigger_s;
  logic [K_W-1:0]           top_slot_s;
  logic [ADDR_W-1:0]        wr_addr_s;
  logic [ADDR_W-1:0]        rd_addr_s;
  logic signed [WGT_W-1:0]  wgt_s;
  logic [DATA_W-1:0]        pix_s;
  logic signed [PROD_W-1:0] prod_s;
  logic [ACC_W-1:0]         prod_ext_s;

  // Arithmetic shift, then clamp to the unsigned output range.
  function automatic logic [DATA_W-1:0] requant(input logic [ACC_W-1:0] acc);
    logic signed [ACC_W-1:0] y;
    logic [DATA_W-1:0]       r;
    y = $signed(acc) >>> OUT_SHIFT;
    if (y[ACC_W-1]) begin
      r = {DATA_W{1'b0}};
    end else if ($unsigned(y) > SAT_MAX) begin
      r = {DATA_W{1'b1}};
    end else begin
      r = y[DATA_W-1:0];
    end
    return r;
  endfunction

  assign accept_s   = in_valid && in_ready_r;
  assign row_ok_s   = (row_cnt_r >= ROW_W'(K - 1)) &&
                      (((int'(row_cnt_r) - (K - 1)) % STRIDE) == 32'sd0);
  assign col_ok_s   = (col_cnt_r >= COL_W'(K - 1)) &&
                      (((int'(col_cnt_r) - (K - 1)) % STRIDE) == 32'sd0);
  assign trigger_s  = (ch_cnt_r == CH_W'(CH - 1)) && row_ok_s && col_ok_s;
  // (row - K + 1) mod K equals (row + 1) mod K
  assign top_slot_s = (wr_slot_r == K_W'(K - 1)) ? K_W'(0) : wr_slot_r + K_W'(1);

  assign wr_addr_s  = ADDR_W'((int'(wr_slot_r) * IMG_W + int'(col_cnt_r)) * CH + int'(ch_cnt_r));
  assign rd_addr_s  = ADDR_W'((int'(rd_slot_r) * IMG_W + int'(win_col_r) + int'(kx_r)) * CH + int'(c_r));

  // Taps are walked in (ky, kx, c) order, which matches the flattened weight order.
  assign wgt_s      = weights[int'(idx_r) * WGT_W +: WGT_W];
  assign pix_s      = line_buf[rd_addr_s];
  assign prod_s     = wgt_s * $signed({1'b0, pix_s});
  assign prod_ext_s = {{(ACC_W - PROD_W){prod_s[PROD_W-1]}}, prod_s};

  assign in_ready   = in_ready_r;
  assign out_valid  = out_valid_r;
  assign out_data   = out_data_r;
  assign out_last   = out_last_r;
  assign busy       = busy_r;

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_STREAM;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_STREAM: begin
        if (accept_s && trigger_s) begin
          state_s = ST_MAC;
        end else begin
          state_s = ST_STREAM;
        end
      end
      ST_MAC: begin
        if (idx_r == IDX_W'(N - 1)) begin
          state_s = ST_HOLD;
        end else begin
          state_s = ST_MAC;
        end
      end
      ST_HOLD: begin
        if (out_valid_r && out_ready) begin
          state_s = ST_STREAM;
        end else begin
          state_s = ST_HOLD;
        end
      end
      default: begin
        state_s = ST_STREAM;
      end
    endcase
  end

  // Raster position counters; advance only on accepted samples
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ch_cnt_r  <= '0;
      col_cnt_r <= '0;
      row_cnt_r <= '0;
      wr_slot_r <= '0;
    end else if (accept_s) begin
      if (ch_cnt_r == CH_W'(CH - 1)) begin
        ch_cnt_r <= '0;
        if (col_cnt_r == COL_W'(IMG_W - 1)) begin
          col_cnt_r <= '0;
          if (row_cnt_r == ROW_W'(IMG_H - 1)) begin
            row_cnt_r <= '0;
            wr_slot_r <= '0;
          end else begin
            row_cnt_r <= row_cnt_r + ROW_W'(1);
            wr_slot_r <= (wr_slot_r == K_W'(K - 1)) ? K_W'(0) : wr_slot_r + K_W'(1);
          end
        end else begin
          col_cnt_r <= col_cnt_r + COL_W'(1);
        end
      end else begin
        ch_cnt_r <= ch_cnt_r + CH_W'(1);
      end
    end
  end

  // Line buffer write; contents need no reset
  always_ff @(posedge clk) begin
    if (accept_s) begin
      line_buf[wr_addr_s] <= in_data;
    end
  end

  // Window latch and serial multiply-accumulate
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_r      <= '0;
      idx_r      <= '0;
      kx_r       <= '0;
      c_r        <= '0;
      rd_slot_r  <= '0;
      win_col_r  <= '0;
      win_last_r <= 1'b0;
    end else begin
      case (state_r)
        ST_STREAM: begin
          if (accept_s && trigger_s) begin
            acc_r      <= '0;
            idx_r      <= '0;
            kx_r       <= '0;
            c_r        <= '0;
            rd_slot_r  <= top_slot_s;
            win_col_r  <= col_cnt_r - COL_W'(K - 1);
            win_last_r <= (row_cnt_r == ROW_W'((OUT_H - 1) * STRIDE + K - 1)) &&
                          (col_cnt_r == COL_W'((OUT_W - 1) * STRIDE + K - 1));
          end
        end
        ST_MAC: begin
          acc_r <= acc_r + prod_ext_s;
          idx_r <= idx_r + IDX_W'(1);
          if (c_r == CH_W'(CH - 1)) begin
            c_r <= '0;
            if (kx_r == K_W'(K - 1)) begin
              kx_r      <= '0;
              rd_slot_r <= (rd_slot_r == K_W'(K - 1)) ? K_W'(0) : rd_slot_r + K_W'(1);
            end else begin
              kx_r <= kx_r + K_W'(1);
            end
          end else begin
            c_r <= c_r + CH_W'(1);
          end
        end
        ST_HOLD: begin
          acc_r <= acc_r;
        end
        default: begin
          acc_r <= acc_r;
        end
      endcase
    end
  end

  // Output registers: result loaded on the first HOLD cycle, held until taken
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_last_r  <= 1'b0;
      in_ready_r  <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      in_ready_r <= (state_s == ST_STREAM);
      busy_r     <= (state_s != ST_STREAM);
      if (state_r == ST_HOLD) begin
        if (!out_valid_r) begin
          out_valid_r <= 1'b1;
          out_data_r  <= requant(acc_r);
          out_last_r  <= win_last_r;
        end else if (out_ready) begin
          out_valid_r <= 1'b0;
        end else begin
          out_valid_r <= 1'b1;
        end
      end else begin
        out_valid_r <= 1'b0;
      end
    end
  end

endmodule
